// File: rtl/freq_meter_multi.sv
`timescale 1ns/1ps
// freq_meter_multi
// Multi-channel gated frequency counter. Counts rising edges on NUM_CH
// asynchronous inputs over a shared window of GATE_CYCLES clocks, then
// streams one result per channel over a valid/ready interface.
//
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   sig_in       - asynchronous test inputs, bit i = channel i
//   start        - single-cycle request for one measurement (ignored while busy)
//   continuous   - level; re-arm automatically after each drain
//   busy         - high while gating or draining
//   m_valid      - result valid
//   m_ready      - downstream accept
//   m_chan       - channel index of the current result
//   m_count      - rising-edge count for that channel (saturating)
//   m_ovf        - count saturated during the gate
//   m_last       - high with the result for channel NUM_CH-1
module freq_meter_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int GATE_CYCLES = 50_000_000,
    parameter int SYNC_STAGES = 2,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] sig_in,
    input  logic              start,
    input  logic              continuous,
    output logic              busy,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CH_W-1:0]   m_chan,
    output logic [CNT_W-1:0]  m_count,
    output logic              m_ovf,
    output logic              m_last
);

    // Gate counter only ever needs to reach GATE_CYCLES-1.
    localparam int                GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                             state_r;
    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_r;
    logic [NUM_CH-1:0]                  hist_r;
    logic [NUM_CH-1:0]                  rise_s;
    logic [GATE_W-1:0]                  gate_cnt_r;
    logic [CNT_W-1:0]                   cnt_r     [NUM_CH];
    logic [NUM_CH-1:0]                  ovf_r;
    logic [CNT_W-1:0]                   cnt_nxt_s [NUM_CH];
    logic [NUM_CH-1:0]                  ovf_nxt_s;
    logic [CNT_W-1:0]                   sh_cnt_r  [NUM_CH];
    logic [NUM_CH-1:0]                  sh_ovf_r;
    logic [CH_W-1:0]                    chan_nxt_s;

    // Saturating increment; result is {ovf, count}. An edge arriving at
    // all-ones is lost, so the count holds and the overflow flag sets.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             ovf,
                                               input logic             inc);
        logic [CNT_W:0] res;
        if (!inc) begin
            res = {ovf, cnt};
        end else if (&cnt) begin
            res = {1'b1, cnt};
        end else begin
            res = {ovf, cnt + CNT_W'(1'b1)};
        end
        return res;
    endfunction

    // Synchronizer chain plus edge history; free-running in every state so
    // a level already high at gate start never looks like a fresh edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '0;
            hist_r <= '0;
        end else begin
            sync_r[0] <= sig_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
            hist_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rise_s = sync_r[SYNC_STAGES-1] & ~hist_r;

    // Next counter values including this cycle's edge, and next drain index.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            {ovf_nxt_s[i], cnt_nxt_s[i]} = sat_inc(cnt_r[i], ovf_r[i], rise_s[i]);
        end
        chan_nxt_s = m_chan + CH_W'(1'b1);
    end

    // Measurement FSM with registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            gate_cnt_r <= '0;
            ovf_r      <= '0;
            sh_ovf_r   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i]    <= '0;
                sh_cnt_r[i] <= '0;
            end
            busy    <= 1'b0;
            m_valid <= 1'b0;
            m_chan  <= '0;
            m_count <= '0;
            m_ovf   <= 1'b0;
            m_last  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start || continuous) begin
                        state_r    <= GATE;
                        busy       <= 1'b1;
                        gate_cnt_r <= '0;
                        ovf_r      <= '0;
                        for (int i = 0; i < NUM_CH; i++) begin
                            cnt_r[i] <= '0;
                        end
                    end
                end
                GATE: begin
                    gate_cnt_r <= gate_cnt_r + GATE_W'(1'b1);
                    ovf_r      <= ovf_nxt_s;
                    for (int i = 0; i < NUM_CH; i++) begin
                        cnt_r[i] <= cnt_nxt_s[i];
                    end
                    if (gate_cnt_r == GATE_LAST) begin
                        // Snapshot includes the final gate cycle's edges.
                        sh_ovf_r <= ovf_nxt_s;
                        for (int i = 0; i < NUM_CH; i++) begin
                            sh_cnt_r[i] <= cnt_nxt_s[i];
                        end
                        state_r <= DRAIN;
                        m_valid <= 1'b1;
                        m_chan  <= '0;
                        m_count <= cnt_nxt_s[0];
                        m_ovf   <= ovf_nxt_s[0];
                        m_last  <= (NUM_CH == 1);
                    end
                end
                DRAIN: begin
                    if (m_valid && m_ready) begin
                        if (m_last) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            if (continuous) begin
                                state_r    <= GATE;
                                gate_cnt_r <= '0;
                                ovf_r      <= '0;
                                for (int i = 0; i < NUM_CH; i++) begin
                                    cnt_r[i] <= '0;
                                end
                            end else begin
                                state_r <= IDLE;
                                busy    <= 1'b0;
                            end
                        end else begin
                            m_chan  <= chan_nxt_s;
                            m_count <= sh_cnt_r[chan_nxt_s];
                            m_ovf   <= sh_ovf_r[chan_nxt_s];
                            m_last  <= (chan_nxt_s == LAST_CH);
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter_multi.sv
`timescale 1ns/1ps
// Testbench for freq_meter_multi: 4 channels, 5-bit counters, 100-cycle gate.
// Expected counts come from counting 0->1 transitions of the sampled input
// history inside the window the gate observes.
module tb_freq_meter_multi;
    localparam int NCH  = 4;
    localparam int CW   = 5;
    localparam int G    = 100;
    localparam int SYN  = 2;
    localparam int MAXV = 31;
    localparam int MAXC = 16384;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           continuous;
    logic           m_ready;
    logic           busy;
    logic           m_valid;
    logic           m_ovf;
    logic           m_last;
    logic [NCH-1:0] sig_in;
    logic [1:0]     m_chan;
    logic [CW-1:0]  m_count;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int rst_cyc     = 0;

    logic [NCH-1:0] samp [MAXC];
    int             mode  [NCH];
    int             per   [NCH];
    int             phase [NCH];
    int             got_cnt [NCH];
    logic           got_ovf [NCH];

    freq_meter_multi #(
        .NUM_CH(NCH), .CNT_W(CW), .GATE_CYCLES(G), .SYNC_STAGES(SYN)
    ) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .start(start),
        .continuous(continuous), .busy(busy), .m_valid(m_valid),
        .m_ready(m_ready), .m_chan(m_chan), .m_count(m_count),
        .m_ovf(m_ovf), .m_last(m_last)
    );

    always #5 clk = ~clk;

    // Cycle index of the latest rising edge and the input value sampled there.
    always @(posedge clk) begin
        if (cyc + 1 < MAXC) samp[cyc+1] <= sig_in;
        cyc <= cyc + 1;
    end

    // Input generator, clock-synchronous, updated on the falling edge.
    initial begin
        sig_in = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) begin
                case (mode[i])
                    0: sig_in[i] = 1'b0;
                    1: sig_in[i] = 1'b1;
                    2: sig_in[i] = (((cyc + 1 + phase[i]) % per[i]) < per[i] / 2) ? 1'b1 : 1'b0;
                    default: sig_in[i] = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
                endcase
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Input as the DUT sees it: everything up to reset reads as 0.
    function automatic bit sv(int r, int ch);
        if (r <= rst_cyc || r < 0 || r >= MAXC) return 1'b0;
        return (samp[r][ch] === 1'b1);
    endfunction

    // Rising edges visible within a gate whose start was sampled at cycle t.
    function automatic int exp_edges(int ch, int t);
        int n = 0;
        for (int r = t - 1; r <= t + G - 2; r++) begin
            if (sv(r, ch) && !sv(r - 1, ch)) n++;
        end
        return n;
    endfunction

    task automatic set_directed();
        per[1] = 4;  phase[1] = 0;
        per[2] = 10; phase[2] = 3;
        mode[0] = 0; mode[1] = 2; mode[2] = 2; mode[3] = 1;
    endtask

    task automatic set_random();
        for (int i = 0; i < NCH; i++) begin
            per[i]   = $urandom_range(2, 12);
            phase[i] = $urandom_range(0, 11);
            mode[i]  = $urandom_range(0, 3);
        end
    endtask

    task automatic pulse_start(output int t);
        start = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Checks one gate (starting at t) and its drain. rmode: 0 ready high,
    // 1 random ready, 2 twenty stall cycles then alternating.
    task automatic run_drain(input int t, input int rmode, input int drop_at,
                             input int poke_at, output int h);
        int   k = 0;
        int   waited = 0;
        int   stall = 0;
        int   n;
        logic cont_hs = 1'b0;
        logic [CW-1:0] ec;
        logic eo;
        logic el;
        h = -1;
        while (cyc < t + G && waited < G + 10) begin
            if (cyc == t + drop_at) continuous = 1'b0;
            start = (cyc == t + poke_at) ? 1'b1 : 1'b0;
            vectors++;
            if (m_valid !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL gate_phase cyc=%0d: valid=%b busy=%b, required valid=0 busy=1",
                         cyc, m_valid, busy);
            end
            waited++;
            @(negedge clk);
        end
        start = 1'b0;
        while (k < NCH && waited < 600) begin
            n  = exp_edges(k, t);
            ec = (n > MAXV) ? CW'(MAXV) : CW'(n);
            eo = (n > MAXV) ? 1'b1 : 1'b0;
            el = (k == NCH - 1) ? 1'b1 : 1'b0;
            got_cnt[k] = int'(m_count);
            got_ovf[k] = m_ovf;
            vectors++;
            if (m_valid !== 1'b1 || m_chan !== 2'(k) || m_count !== ec ||
                m_ovf !== eo || m_last !== el) begin
                miscompares++;
                $display("FAIL drain_ch%0d cyc=%0d: valid=%b chan=%0d count=%0d ovf=%b last=%b, required valid=1 chan=%0d count=%0d ovf=%b last=%b",
                         k, cyc, m_valid, m_chan, m_count, m_ovf, m_last, k, ec, eo, el);
            end
            case (rmode)
                0: m_ready = 1'b1;
                1: m_ready = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
                default: m_ready = (stall >= 20 && (stall % 2 == 0)) ? 1'b1 : 1'b0;
            endcase
            stall++;
            if (m_ready) begin
                k++;
                cont_hs = continuous;
            end
            waited++;
            @(negedge clk);
        end
        m_ready = 1'b0;
        if (k == NCH) begin
            h = cyc;
        end else begin
            miscompares++;
            $display("FAIL drain_timeout cyc=%0d: got %0d channels, required %0d", cyc, k, NCH);
        end
        vectors++;
        if (m_valid !== 1'b0 || busy !== cont_hs) begin
            miscompares++;
            $display("FAIL after_last cyc=%0d: valid=%b busy=%b, required valid=0 busy=%b",
                     cyc, m_valid, busy, cont_hs);
        end
    endtask

    task automatic check_fixed(input string name, input int ch, input int ecnt, input logic eovf);
        vectors++;
        if (got_cnt[ch] != ecnt || got_ovf[ch] !== eovf) begin
            miscompares++;
            $display("FAIL %s ch%0d: count=%0d ovf=%b, required count=%0d ovf=%b",
                     name, ch, got_cnt[ch], got_ovf[ch], ecnt, eovf);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; continuous = 1'b0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_cyc = cyc;
        vectors++;
        if (busy !== 1'b0 || m_valid !== 1'b0 || m_chan !== 2'd0 ||
            m_count !== 5'd0 || m_ovf !== 1'b0 || m_last !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b valid=%b chan=%0d count=%0d ovf=%b last=%b, required all 0",
                     busy, m_valid, m_chan, m_count, m_ovf, m_last);
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || m_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_hold cyc=%0d: busy=%b valid=%b, required 0 0", cyc, busy, m_valid);
            end
        end
    endtask

    task automatic test_pattern();
        int t;
        int h;
        set_directed();
        repeat (12) @(negedge clk);
        pulse_start(t);
        run_drain(t, 0, -1, -1, h);
        check_fixed("pattern", 0, 0, 1'b0);
        check_fixed("pattern", 1, 25, 1'b0);
        check_fixed("pattern", 2, 10, 1'b0);
        check_fixed("pattern", 3, 0, 1'b0);
    endtask

    task automatic test_saturation();
        int t;
        int h;
        per[0] = 2; phase[0] = 0;
        per[1] = 4; phase[1] = 1;
        per[2] = 2; phase[2] = 1;
        mode[0] = 2; mode[1] = 2; mode[2] = 2; mode[3] = 3;
        repeat (12) @(negedge clk);
        pulse_start(t);
        run_drain(t, 0, -1, -1, h);
        check_fixed("saturate", 0, MAXV, 1'b1);
        check_fixed("saturate", 1, 25, 1'b0);
        check_fixed("saturate", 2, MAXV, 1'b1);
    endtask

    task automatic test_random();
        int t;
        int h;
        for (int it = 0; it < 6; it++) begin
            set_random();
            repeat ($urandom_range(3, 8)) @(negedge clk);
            pulse_start(t);
            run_drain(t, $urandom_range(0, 1), -1, -1, h);
        end
    endtask

    task automatic test_backpressure();
        int t;
        int h;
        set_random();
        repeat (4) @(negedge clk);
        pulse_start(t);
        run_drain(t, 2, -1, -1, h);
    endtask

    task automatic test_back_to_back();
        int t;
        int h;
        set_random();
        repeat (4) @(negedge clk);
        continuous = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        run_drain(t, 1, -1, 30, h);
        t = h;
        run_drain(t, 0, -1, -1, h);
        t = h;
        run_drain(t, 0, 50, -1, h);
        repeat (20) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || m_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL stay_idle cyc=%0d: busy=%b valid=%b, required 0 0", cyc, busy, m_valid);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        int t;
        int h;
        int waited = 0;
        set_directed();
        repeat (12) @(negedge clk);
        pulse_start(t);
        while (cyc < t + G && waited < G + 10) begin
            waited++;
            @(negedge clk);
        end
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (m_valid !== 1'b1 || m_chan !== 2'd2) begin
            miscompares++;
            $display("FAIL pre_reset_chan: valid=%b chan=%0d, required valid=1 chan=2", m_valid, m_chan);
        end
        m_ready = 1'b0;
        rst = 1'b1;
        rst_cyc = cyc + 1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || m_chan !== 2'd0 || m_last !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_drain_reset: valid=%b busy=%b chan=%0d last=%b, required 0 0 0 0",
                     m_valid, busy, m_chan, m_last);
        end
        repeat (12) @(negedge clk);
        pulse_start(t);
        run_drain(t, 0, -1, -1, h);
        check_fixed("post_reset", 0, 0, 1'b0);
        check_fixed("post_reset", 1, 25, 1'b0);
        check_fixed("post_reset", 2, 10, 1'b0);
        check_fixed("post_reset", 3, 0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; continuous = 1'b0; m_ready = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            mode[i] = 0; per[i] = 2; phase[i] = 0;
            got_cnt[i] = 0; got_ovf[i] = 1'b0;
        end
        test_reset();
        test_pattern();
        test_saturation();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
